ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
- Hazard and forwarding controller for the EX stage.
- Tracks destination registers of in-flight instructions (EX, MEM, WB slots) in an internal shadow pipeline.
- Drives the four EX operand-mux selects, the one-cycle load-use stall and the branch/jump flush.
- Sits between the ID/EX pipeline register and the EX stage. All select outputs are registered, so they are valid for the whole cycle the instruction occupies EX.

Parameters:
- XLEN_REGS, 32, number of architectural registers; register index width is clog2(XLEN_REGS).
- FLUSH_CYCLES, 2, cycles the ID input is squashed after a taken branch/jump (minimum 1).
- CNT_W, 32, width of the stall and flush event counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs1  in  5  source register 1 index.
- id_rs2  in  5  source register 2 index.
- id_rd  in  5  destination register index.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- id_use_pc  in  1  ALU operand 1 is the PC (auipc, jal).
- id_use_imm  in  1  ALU operand 2 is the immediate.
- pc_select  in  1  taken branch/jump resolved in EX this cycle.
- data1_sel_ALU  out  2  00 reg, 01 PC, 10 WB, 11 MEM.
- data2_sel_ALU  out  2  00 reg, 01 imm, 10 WB, 11 MEM.
- data1_sel_BJ  out  2  00 reg, 10 WB, 11 MEM (01 is never driven).
- data2_sel_BJ  out  2  same encoding as data1_sel_BJ; also selects the store-data mux.
- stall_if_id  out  1  hold the PC and IF/ID register.
- bubble_id_ex  out  1  load a NOP into ID/EX.
- flush_if_id  out  1  clear the IF/ID register.
- stall_count  out  CNT_W  number of load-use stall cycles.
- flush_count  out  CNT_W  number of taken redirects.

Behaviour:
- Reset (async): all selects 00; stall_if_id, bubble_id_ex, flush_if_id 0; counters 0; all shadow slots invalid; FSM to RUN.
- Shadow pipeline. Each slot holds {valid, rd, reg_write, mem_read}. On every edge: WB<=MEM, MEM<=EX, EX<=ID-insert.
  - ID-insert is the ID fields when the instruction advances.
  - ID-insert is an invalid bubble when stalling, flushing or in FLUSH state.
- Forward decision, computed combinationally from the current EX/MEM slots and registered into the select outputs when the instruction advances to EX:
  - rs matches EX slot (valid, reg_write, rd != 0): select 11 (result will be in MEM).
  - else rs matches MEM slot: select 10 (result will be in WB).
  - else 00.
  - EX-slot match has priority over MEM-slot match.
  - rs == x0 never forwards.
- ALU select overrides: id_use_pc forces data1_sel_ALU=01; id_use_imm forces data2_sel_ALU=01.
- BJ selects and store data always use the forwarding result regardless of the use_pc/use_imm overrides.
- Load-use condition:
  - id_valid, EX slot valid with mem_read and rd != 0, and rd equals id_rs1, or equals id_rs2 when rs2 is read.
  - Treat rs2 as read when !id_use_imm or the instruction is a store/branch; conservatively, always compare rs2.
- FSM states: RUN, STALL, FLUSH.
  - RUN, load-use: stall_if_id=1 and bubble_id_ex=1 combinationally this cycle; selects go to 00 next cycle; stall_count++; next state STALL.
  - STALL: the load is now in the MEM slot. Same instruction is re-evaluated (yields 10); advances; next state RUN. A back-to-back load-use cannot re-trigger because the EX slot now holds a bubble.
  - pc_select=1, any state: flush_if_id=1 and bubble_id_ex=1 this cycle; stall_if_id=0; the ID instruction is not inserted; flush_count++; next state FLUSH with counter=FLUSH_CYCLES-1.
    - If FLUSH_CYCLES=1, next state is RUN.
    - pc_select has priority over load-use.
  - FLUSH: id_valid is treated as 0 and bubbles are inserted. Counter decrements; at 0 the next state is RUN. A new pc_select during FLUSH restarts the count.
- Counters saturate at all-ones; they do not wrap.
- Reset asserted mid-stall or mid-flush: immediate return to reset values; the next instruction after reset release sees empty shadow slots.

Test Plan:
- Forward from MEM: add x5,x1,x2 then sub x6,x5,x3. In sub's EX cycle data1_sel_ALU=11, data2_sel_ALU=00, no stall.
- Forward from WB: add x5; then nop; then or x7,x0,x5. data2_sel_ALU=10. x0 source: add x8,x0,x0 after a write to x0 gives selects 00.
- Load-use: lw x4,0(x1) then add x9,x4,x4. One cycle with stall_if_id=1 and bubble_id_ex=1; next cycle add issues with data1_sel_ALU=data2_sel_ALU=10; stall_count=1.
- Immediate/PC override: auipc x3 following a write to x3's source gives data1_sel_ALU=01. sw x5 after add x5 gives data2_sel_ALU=01 and data2_sel_BJ=11.
- Branch flush, FLUSH_CYCLES=2: pc_select pulse gives flush_if_id=1 for 1 cycle and two bubbles in the shadow pipeline. Next instruction forwards nothing from squashed ones; flush_count=1. pc_select coinciding with load-use: flush wins, stall_count unchanged.
- Async reset asserted in the STALL state between clock edges: outputs zero immediately; after release the first instruction has selects 00.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard and forwarding controller: tracks in-flight destinations in a shadow
// pipeline and drives registered operand-mux selects, the load-use stall and redirect flush.
module ex_hazard_ctrl #(
  parameter int unsigned XLEN_REGS    = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [$clog2(XLEN_REGS)-1:0] id_rs1,
  input  logic [$clog2(XLEN_REGS)-1:0] id_rs2,
  input  logic [$clog2(XLEN_REGS)-1:0] id_rd,
  input  logic                         id_reg_write,
  input  logic                         id_mem_read,
  input  logic                         id_use_pc,
  input  logic                         id_use_imm,
  input  logic                         pc_select,
  output logic [1:0]                   data1_sel_ALU,
  output logic [1:0]                   data2_sel_ALU,
  output logic [1:0]                   data1_sel_BJ,
  output logic [1:0]                   data2_sel_BJ,
  output logic                         stall_if_id,
  output logic                         bubble_id_ex,
  output logic                         flush_if_id,
  output logic [CNT_W-1:0]             stall_count,
  output logic [CNT_W-1:0]             flush_count
);

  localparam int unsigned RegW = $clog2(XLEN_REGS);
  localparam int unsigned FcW  = $clog2(FLUSH_CYCLES + 1);

  typedef struct packed {
    logic            valid;
    logic [RegW-1:0] rd;
    logic            reg_write;
    logic            mem_read;
  } ex_slot_t;

  // A WB-stage producer is already visible through the register file, so only the
  // slots that feed the forwarding muxes are kept.
  typedef struct packed {
    logic            valid;
    logic [RegW-1:0] rd;
    logic            reg_write;
  } mem_slot_t;

  typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

  state_e          state_q, state_d;
  logic [FcW-1:0]  fcnt_q, fcnt_d;
  ex_slot_t        ex_q, id_slot;
  mem_slot_t       mem_q;
  logic [1:0]      d1a_d, d2a_d, d1b_d, d2b_d;
  logic [1:0]      fwd1, fwd2;
  logic            id_live, load_use, stall, advance;

  function automatic logic [1:0] fwd_sel(input logic [RegW-1:0] rs, input ex_slot_t ex,
                                         input mem_slot_t mem);
    if (rs == '0) return 2'b00;
    if (ex.valid && ex.reg_write && (ex.rd == rs)) return 2'b11;
    if (mem.valid && mem.reg_write && (mem.rd == rs)) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    id_live  = id_valid && (state_q != StFlush);
    // rs2 is always compared: a spurious stall is harmless, a missed one is not.
    load_use = id_live && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
               ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
    stall    = load_use && !pc_select;
    advance  = id_live && !stall && !pc_select;

    stall_if_id  = stall;
    bubble_id_ex = stall || pc_select;
    flush_if_id  = pc_select;

    id_slot = '{valid: advance, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

    fwd1  = fwd_sel(id_rs1, ex_q, mem_q);
    fwd2  = fwd_sel(id_rs2, ex_q, mem_q);
    d1a_d = 2'b00;
    d2a_d = 2'b00;
    d1b_d = 2'b00;
    d2b_d = 2'b00;
    if (advance) begin
      d1a_d = id_use_pc  ? 2'b01 : fwd1;
      d2a_d = id_use_imm ? 2'b01 : fwd2;
      d1b_d = fwd1;
      d2b_d = fwd2;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (pc_select) begin
      fcnt_d  = FcW'(FLUSH_CYCLES - 1);
      state_d = (FLUSH_CYCLES > 1) ? StFlush : StRun;
    end else begin
      unique case (state_q)
        StRun:   if (stall) state_d = StStall;
        StStall: state_d = StRun;
        StFlush: begin
          fcnt_d = fcnt_q - 1'b1;
          if (fcnt_d == '0) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StRun;
      fcnt_q        <= '0;
      ex_q          <= '0;
      mem_q         <= '0;
      data1_sel_ALU <= 2'b00;
      data2_sel_ALU <= 2'b00;
      data1_sel_BJ  <= 2'b00;
      data2_sel_BJ  <= 2'b00;
      stall_count   <= '0;
      flush_count   <= '0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      ex_q          <= id_slot;
      mem_q         <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
      data1_sel_ALU <= d1a_d;
      data2_sel_ALU <= d2a_d;
      data1_sel_BJ  <= d1b_d;
      data2_sel_BJ  <= d2b_d;
      if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (pc_select && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: directed program table, corner sequences and
// randomized traffic against an in-flight-instruction reference model.
module tb_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0, id_use_pc = 1'b0, id_use_imm = 1'b0;
  logic       pc_select = 1'b0, pc_select2 = 1'b0;

  logic [1:0]  d1a, d2a, d1b, d2b;
  logic        stall_if_id, bubble_id_ex, flush_if_id;
  logic [31:0] stall_count, flush_count;
  logic [1:0]  d1a2, d2a2, d1b2, d2b2;
  logic        stall2, bubble2, flush2;
  logic [1:0]  stall_count2, flush_count2;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_use_pc(id_use_pc), .id_use_imm(id_use_imm), .pc_select(pc_select),
    .data1_sel_ALU(d1a), .data2_sel_ALU(d2a), .data1_sel_BJ(d1b), .data2_sel_BJ(d2b),
    .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  ex_hazard_ctrl #(.XLEN_REGS(32), .FLUSH_CYCLES(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_use_pc(id_use_pc), .id_use_imm(id_use_imm), .pc_select(pc_select2),
    .data1_sel_ALU(d1a2), .data2_sel_ALU(d2a2), .data1_sel_BJ(d1b2), .data2_sel_BJ(d2b2),
    .stall_if_id(stall2), .bubble_id_ex(bubble2), .flush_if_id(flush2),
    .stall_count(stall_count2), .flush_count(flush_count2)
  );

  typedef struct {
    bit v; bit [4:0] rs1, rs2, rd; bit rw, mr, upc, uimm, pc;
    bit e_stall, chk_bub; bit [1:0] d1a, d2a, d1b, d2b; int sc, fc;
  } vec_t;

  typedef struct { bit v; bit [4:0] rd; bit rw, ld; } inst_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(int v, int rs1, int rs2, int rd, int rw, int mr, int upc,
                              int uimm, int pc, int st, int cb, int e1a, int e2a, int e1b,
                              int e2b, int sc, int fc);
    vec_t r;
    r.v = v[0]; r.rs1 = rs1[4:0]; r.rs2 = rs2[4:0]; r.rd = rd[4:0];
    r.rw = rw[0]; r.mr = mr[0]; r.upc = upc[0]; r.uimm = uimm[0]; r.pc = pc[0];
    r.e_stall = st[0]; r.chk_bub = cb[0];
    r.d1a = e1a[1:0]; r.d2a = e2a[1:0]; r.d1b = e1b[1:0]; r.d2b = e2b[1:0];
    r.sc = sc; r.fc = fc;
    return r;
  endfunction

  task automatic drive(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit [4:0] rd, input bit rw, input bit mr, input bit upc,
                       input bit uimm, input bit pc);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_reg_write = rw;
    id_mem_read = mr; id_use_pc = upc; id_use_imm = uimm; pc_select = pc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    pc_select2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply_row(input vec_t r, input int idx);
    @(negedge clk);
    drive(r.v, r.rs1, r.rs2, r.rd, r.rw, r.mr, r.upc, r.uimm, r.pc);
    #1;
    chk($sformatf("row%0d stall", idx), stall_if_id, r.e_stall);
    chk($sformatf("row%0d flush", idx), flush_if_id, r.pc);
    if (r.chk_bub) chk($sformatf("row%0d bubble", idx), bubble_id_ex, r.e_stall | r.pc);
    @(posedge clk);
    #1;
    chk($sformatf("row%0d d1_alu", idx), d1a, r.d1a);
    chk($sformatf("row%0d d2_alu", idx), d2a, r.d2a);
    chk($sformatf("row%0d d1_bj", idx), d1b, r.d1b);
    chk($sformatf("row%0d d2_bj", idx), d2b, r.d2b);
    chk($sformatf("row%0d stall_cnt", idx), stall_count, r.sc);
    chk($sformatf("row%0d flush_cnt", idx), flush_count, r.fc);
  endtask

  // Reference: the two instructions ahead of ID, nearest first; a match one slot ahead
  // will sit in MEM (11), two slots ahead in WB (10).
  function automatic bit [1:0] ref_fwd(input bit [4:0] rs, input inst_t ahead [2]);
    if (rs == 0) return 2'b00;
    for (int d = 0; d < 2; d++)
      if (ahead[d].v && ahead[d].rw && ahead[d].rd == rs) return (d == 0) ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  initial begin
    // v rs1 rs2 rd rw mr upc uimm pc | stall chkbub | d1a d2a d1b d2b | sc fc
    tbl.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); // add x5,x1,x2
    tbl.push_back(mk(1, 5, 3, 6, 1, 0, 0, 0, 0, 0, 1, 3, 0, 3, 0, 0, 0)); // sub x6,x5,x3
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); // nop
    tbl.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); // add x5
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); // nop
    tbl.push_back(mk(1, 0, 5, 7, 1, 0, 0, 0, 0, 0, 1, 0, 2, 0, 2, 0, 0)); // or x7,x0,x5
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); // add x0,x1,x1
    tbl.push_back(mk(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); // add x8,x0,x0
    tbl.push_back(mk(1, 1, 0, 4, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0)); // lw x4,0(x1)
    tbl.push_back(mk(1, 4, 4, 9, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0)); // add x9 stalls
    tbl.push_back(mk(1, 4, 4, 9, 1, 0, 0, 0, 0, 0, 1, 2, 2, 2, 2, 1, 0)); // add x9 issues
    tbl.push_back(mk(1, 1, 2, 10, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0)); // add x10
    tbl.push_back(mk(1, 10, 0, 3, 1, 0, 1, 1, 0, 0, 1, 1, 1, 3, 0, 1, 0)); // pc-op x3
    tbl.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0)); // add x5
    tbl.push_back(mk(1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 3, 1, 0)); // sw x5,0(x1)
    tbl.push_back(mk(1, 5, 5, 11, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1)); // redirect
    tbl.push_back(mk(1, 11, 5, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); // squashed
    tbl.push_back(mk(1, 11, 12, 13, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1)); // add x13
    tbl.push_back(mk(1, 1, 0, 4, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1)); // lw x4
    tbl.push_back(mk(1, 4, 4, 9, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 2)); // flush beats stall
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2)); // flush cycle
    tbl.push_back(mk(1, 4, 9, 14, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2)); // add x14

    // Reset state
    #2;
    chk("reset d1_alu", d1a, 2'b00);
    chk("reset d2_alu", d2a, 2'b00);
    chk("reset d1_bj", d1b, 2'b00);
    chk("reset d2_bj", d2b, 2'b00);
    chk("reset stall", stall_if_id, 1'b0);
    chk("reset bubble", bubble_id_ex, 1'b0);
    chk("reset flush", flush_if_id, 1'b0);
    chk("reset stall_cnt", stall_count, 0);
    chk("reset flush_cnt", flush_count, 0);
    do_reset();

    foreach (tbl[i]) apply_row(tbl[i], i);

    // Async reset while in the stall-recovery cycle
    do_reset();
    @(negedge clk); drive(1, 1, 0, 4, 1, 1, 0, 1, 0);
    @(negedge clk); drive(1, 4, 4, 9, 1, 0, 0, 0, 0);
    #1 chk("ar stall before", stall_if_id, 1'b1);
    @(posedge clk); #1;
    chk("ar stall_cnt before", stall_count, 1);
    #1 rst = 1'b1;
    #1;
    chk("ar d1_alu", d1a, 2'b00);
    chk("ar d2_alu", d2a, 2'b00);
    chk("ar stall", stall_if_id, 1'b0);
    chk("ar bubble", bubble_id_ex, 1'b0);
    chk("ar stall_cnt", stall_count, 0);
    @(negedge clk); rst = 1'b0;
    #1 chk("ar post stall", stall_if_id, 1'b0);
    @(posedge clk); #1;
    chk("ar post d1_alu", d1a, 2'b00);
    chk("ar post d2_alu", d2a, 2'b00);
    chk("ar post d1_bj", d1b, 2'b00);

    // FLUSH_CYCLES=1: the instruction right after a redirect is live; counters saturate
    do_reset();
    @(negedge clk); drive(1, 1, 2, 5, 1, 0, 0, 0, 0); pc_select2 = 1'b0;
    @(negedge clk); drive(1, 1, 2, 20, 1, 0, 0, 0, 0); pc_select2 = 1'b1;
    @(negedge clk); drive(1, 5, 3, 6, 1, 0, 0, 0, 0); pc_select2 = 1'b0;
    @(posedge clk); #1;
    chk("fc1 d1_alu", d1a2, 2'b10);
    chk("fc1 flush_cnt", flush_count2, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); pc_select2 = 1'b1;
    end
    @(negedge clk); pc_select2 = 1'b0;
    chk("sat flush_cnt", flush_count2, 2'b11);

    // Randomized traffic against the reference model
    do_reset();
    begin
      inst_t ahead [2];
      int squash = 0;
      longint esc = 0, efc = 0;
      bit [1:0] e1a, e2a, e1b, e2b;
      ahead[0] = '{default: 0};
      ahead[1] = '{default: 0};
      for (int c = 0; c < 400; c++) begin
        bit v, rw, mr, upc, uimm, pc, live, lu, est, adv;
        bit [4:0] rs1, rs2, rd;
        inst_t nw;
        @(negedge clk);
        v = ($urandom_range(0, 7) != 0);
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        rw = ($urandom_range(0, 3) != 0);
        mr = ($urandom_range(0, 2) == 0);
        upc = ($urandom_range(0, 5) == 0);
        uimm = ($urandom_range(0, 2) == 0);
        pc = ($urandom_range(0, 11) == 0);
        drive(v, rs1, rs2, rd, rw, mr, upc, uimm, pc);
        live = v && (squash == 0);
        lu = live && ahead[0].v && ahead[0].ld && ahead[0].rd != 0 &&
             (ahead[0].rd == rs1 || ahead[0].rd == rs2);
        est = lu && !pc;
        adv = live && !est && !pc;
        #1;
        chk("rnd stall", stall_if_id, est);
        chk("rnd flush", flush_if_id, pc);
        if (squash == 0) chk("rnd bubble", bubble_id_ex, est | pc);
        e1a = 2'b00; e2a = 2'b00; e1b = 2'b00; e2b = 2'b00;
        if (adv) begin
          e1b = ref_fwd(rs1, ahead);
          e2b = ref_fwd(rs2, ahead);
          e1a = upc ? 2'b01 : e1b;
          e2a = uimm ? 2'b01 : e2b;
        end
        if (est) esc++;
        if (pc) efc++;
        nw = '{v: adv, rd: rd, rw: rw, ld: mr};
        ahead[1] = ahead[0];
        ahead[0] = nw;
        if (pc) squash = 1;
        else if (squash > 0) squash--;
        @(posedge clk); #1;
        chk("rnd d1_alu", d1a, e1a);
        chk("rnd d2_alu", d2a, e2a);
        chk("rnd d1_bj", d1b, e1b);
        chk("rnd d2_bj", d2b, e2b);
        chk("rnd stall_cnt", stall_count, esc);
        chk("rnd flush_cnt", flush_count, efc);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
